uart_rx_frame_ctrl: RTL and testbench

Sequencing controller for the UART receive datapath. Times each serial frame from the baud generator's oversample strobe and samples at bit centres. Assembles data LSB first, checks the stop bit, and presents completed bytes on a valid/ready interface toward the RX FIFO. Sits between the baud generator and the RX FIFO, replacing ad-hoc sample_edge/counter glue with a single owner of frame timing and error flags.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared state type and default sizing for the UART receive frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_RX_DATA_BITS_DEF  = 8;
    localparam int UART_RX_OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: bit-centre sampling, byte hand-off, sticky errors.
// Define UART_RX_PARITY_EN to add a parity bit check (parity_odd/parity_err).
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = UART_RX_DATA_BITS_DEF,
    parameter int OVERSAMPLE = UART_RX_OVERSAMPLE_DEF
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 utrrst,
    input  logic                 baud_tick,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 err_clear,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif
    logic                 done;
    logic                 rxd_s;

    uart_rx_sync u_sync (
        .clk_i (pclk),
        .rst_i (preset),
        .d_i   (uart_rxd),
        .q_o   (rxd_s)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        done    = 1'b0;

        if (valid_q && rx_ready) valid_d = 1'b0;
        if (err_clear) begin
            ferr_d = 1'b0;
            oerr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
        end

        if (!utrrst) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_q == HALF_TICK) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            // A start bit gone high by its centre is a glitch.
                            state_d = rxd_s ? IDLE : DATA;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_q == FULL_TICK) begin
                            tick_d  = '0;
                            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                            bit_d   = bit_q + 1'b1;
                            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state_d = PARITY;
`else
                                state_d = STOP;
`endif
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        if (tick_q == FULL_TICK) begin
                            tick_d  = '0;
                            state_d = STOP;
                            if (rxd_s != (^shift_q ^ parity_odd)) perr_d = 1'b1;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (tick_q == FULL_TICK) begin
                            tick_d = '0;
                            done   = 1'b1;
                            if (rxd_s) begin
                                state_d = IDLE;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = BREAK;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Hold here so a line stuck low cannot look like a new start.
                    if (rxd_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: vector table, corner sequences,
// and randomized frames against a transaction-level receiver model.
module tb_uart_rx_frame_ctrl;

    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int TDIV    = 4;
    localparam int BIT_CYC = OS * TDIV;

    logic          pclk;
    logic          preset;
    logic          utrrst;
    logic          baud_tick;
    logic          uart_rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun_err;
    logic          err_clear;
    logic          rx_busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd;
    logic          parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ph     = 0;

    uart_rx_frame_ctrl #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .utrrst      (utrrst),
        .baud_tick   (baud_tick),
        .uart_rxd    (uart_rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clear   (err_clear),
`ifdef UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .rx_busy     (rx_busy)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge pclk);
            ph = (ph + 1) % TDIV;
            baud_tick = (ph == 0);
        end
    end

    always @(negedge pclk) begin
        if (rx_valid) vcnt <= vcnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        logic       clr;
        logic       pulse;
        logic [7:0] ed;
        logic       ev;
        logic       efe;
        logic       eoe;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        cyc(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ parity_odd);
`endif
        drive_bit(stop);
    endtask

    task automatic clr_pulse();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] tmp;
        logic [7:0] rd;
        logic       rs;
        logic       rdrn;
        logic       rcl;
        logic [7:0] m_d;
        logic       m_pend;
        logic       m_fe;
        logic       m_oe;
        int         base;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};

        preset    = 1'b1;
        utrrst    = 1'b1;
        uart_rxd  = 1'b1;
        rx_ready  = 1'b0;
        err_clear = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        cyc(3);
        preset = 1'b0;
        cyc(2);
        chk("reset_data", 32'(rx_data), 32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_oerr", 32'(overrun_err), 32'h0);
        chk("reset_busy", 32'(rx_busy), 32'h0);
`ifdef UART_RX_PARITY_EN
        chk("reset_perr", 32'(parity_err), 32'h0);
`endif

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].clr) clr_pulse();
            rx_ready = tbl[i].rdy;
            base = vcnt;
            send_frame(tbl[i].d, tbl[i].stop);
            uart_rxd = 1'b1;
            cyc(40);
            chk($sformatf("vec%0d_data", i), 32'(rx_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(tbl[i].efe));
            chk($sformatf("vec%0d_oerr", i), 32'(overrun_err), 32'(tbl[i].eoe));
            chk($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'h0);
            if (tbl[i].pulse) chk($sformatf("vec%0d_pulse", i), 32'(vcnt - base), 32'd1);
        end
        rx_ready = 1'b0;

        drain();
        clr_pulse();
        uart_rxd = 1'b0;
        cyc(8);
        chk("glitch_start", 32'(rx_busy), 32'h1);
        cyc(4);
        uart_rxd = 1'b1;
        cyc(60);
        chk("glitch_busy", 32'(rx_busy), 32'h0);
        chk("glitch_valid", 32'(rx_valid), 32'h0);
        chk("glitch_ferr", 32'(frame_err), 32'h0);
        chk("glitch_oerr", 32'(overrun_err), 32'h0);

        rx_ready = 1'b1;
        base = vcnt;
        send_frame(8'h3C, 1'b0);
        cyc(40 * TDIV);
        chk("break_hold", 32'(rx_busy), 32'h1);
        chk("break_data", 32'(rx_data), 32'h3C);
        chk("break_ferr", 32'(frame_err), 32'h1);
        uart_rxd = 1'b1;
        cyc(60);
        chk("break_exit", 32'(rx_busy), 32'h0);
        chk("break_single", 32'(vcnt - base), 32'd1);
        rx_ready = 1'b0;
        clr_pulse();

        tmp = 8'h5A;
        base = vcnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(tmp[i]);
        utrrst = 1'b0;
        cyc(1);
        chk("abort_idle", 32'(rx_busy), 32'h0);
        for (int i = 4; i < DB; i++) drive_bit(tmp[i]);
        drive_bit(1'b1);
        cyc(40);
        chk("abort_novalid", 32'(vcnt - base), 32'd0);
        chk("abort_ferr", 32'(frame_err), 32'h0);
        utrrst = 1'b1;
        cyc(2);
        send_frame(tmp, 1'b1);
        uart_rxd = 1'b1;
        cyc(40);
        chk("reen_data", 32'(rx_data), 32'h5A);
        chk("reen_valid", 32'(rx_valid), 32'h1);
        chk("reen_ferr", 32'(frame_err), 32'h0);

        uart_rxd = 1'b0;
        cyc(BIT_CYC);
        uart_rxd = 1'b1;
        cyc(20);
        chk("mid_busy", 32'(rx_busy), 32'h1);
        preset = 1'b1;
        cyc(1);
        preset = 1'b0;
        chk("mid_rst_busy", 32'(rx_busy), 32'h0);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        chk("mid_rst_data", 32'(rx_data), 32'h0);
        cyc(BIT_CYC * 10);
        chk("mid_rst_quiet", 32'(rx_busy), 32'h0);

        m_d = 8'h00;
        m_pend = 1'b0;
        m_fe = 1'b0;
        m_oe = 1'b0;
        for (int n = 0; n < 20; n++) begin
            rd   = 8'($urandom_range(0, 255));
            rs   = ($urandom_range(0, 4) != 0);
            rdrn = 1'($urandom_range(0, 1));
            rcl  = ($urandom_range(0, 3) == 0);
            if (rcl) begin
                clr_pulse();
                m_fe = 1'b0;
                m_oe = 1'b0;
            end
            if (rdrn) begin
                drain();
                m_pend = 1'b0;
            end
            send_frame(rd, rs);
            uart_rxd = 1'b1;
            cyc(40);
            if (m_pend) begin
                m_oe = 1'b1;
            end else begin
                m_d = rd;
                m_pend = 1'b1;
            end
            if (!rs) m_fe = 1'b1;
            chk($sformatf("rnd%0d_data", n), 32'(rx_data), 32'(m_d));
            chk($sformatf("rnd%0d_valid", n), 32'(rx_valid), 32'(m_pend));
            chk($sformatf("rnd%0d_ferr", n), 32'(frame_err), 32'(m_fe));
            chk($sformatf("rnd%0d_oerr", n), 32'(overrun_err), 32'(m_oe));
        end

`ifdef UART_RX_PARITY_EN
        drain();
        clr_pulse();
        parity_odd = 1'b0;
        tmp = 8'h07;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(tmp[i]);
        drive_bit(1'b0);
        drive_bit(1'b1);
        cyc(40);
        chk("par_bad_perr", 32'(parity_err), 32'h1);
        chk("par_bad_data", 32'(rx_data), 32'h07);
        drain();
        clr_pulse();
        chk("par_clear", 32'(parity_err), 32'h0);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(tmp[i]);
        drive_bit(1'b1);
        drive_bit(1'b1);
        cyc(40);
        chk("par_good_perr", 32'(parity_err), 32'h0);
        chk("par_good_valid", 32'(rx_valid), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
